fp_exec_sequencer: RTL and testbench

- Sequencing stage directly upstream of the combinational floating-point ALU in the FP datapath.
- Accepts one FP operation at a time from the decode/issue side over a valid/ready handshake and registers the opcode and operands.
- Holds the operands on the ALU inputs for an opcode-dependent number of cycles, then captures the ALU result and exception flags.
- Presents the result to writeback over a valid/ready handshake and maintains a sticky exception-flag register.

---
 rtl/fp_exec_sequencer.sv | 129 ++++++++++++
 tb/tb_fp_exec_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exec_sequencer.sv
// Sequencer between FP issue and the combinational FP ALU: holds operands for an
// opcode-dependent latency, captures result/flags, keeps sticky flags. Optional trap: FP_EXEC_TRAP_EN.
module fp_exec_sequencer #(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_dest,
    output logic [3:0]  falu_opcode,
    output logic [31:0] falu_a,
    output logic [31:0] falu_b,
    input  logic [31:0] falu_result,
    input  logic [6:0]  falu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest,
    output logic [6:0]  out_flags,
    output logic [5:0]  sticky_flags,
    input  logic        sticky_clear,
`ifdef FP_EXEC_TRAP_EN
    input  logic [5:0]  trap_mask,
    output logic        trap,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       issue, capture;

    // Counter holds remaining execute cycles minus one; non-latency ops take one cycle.
    function automatic logic [3:0] load_value(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001: return 4'(LAT_ADD - 1);
            4'b0010:          return 4'(LAT_MUL - 1);
            4'b0100, 4'b0101: return 4'(LAT_DIV - 1);
            default:          return 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    issue      = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, because their reset values are architecturally visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            falu_opcode <= '0;
            falu_a      <= '0;
            falu_b      <= '0;
            out_dest    <= '0;
            cnt         <= '0;
            out_result  <= '0;
            out_flags   <= '0;
        end else begin
            if (issue) begin
                falu_opcode <= in_opcode;
                falu_a      <= in_a;
                falu_b      <= in_b;
                out_dest    <= in_dest;
                cnt         <= load_value(in_opcode);
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                out_result <= falu_result;
                out_flags  <= falu_flags;
            end
        end
    end

    // A clear on the capture edge wipes the old bits but the new op's flags still land.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             sticky_flags <= '0;
        else if (capture)      sticky_flags <= (sticky_clear ? 6'd0 : sticky_flags) | falu_flags[6:1];
        else if (sticky_clear) sticky_flags <= '0;
    end

`ifdef FP_EXEC_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trap <= 1'b0;
        else       trap <= capture && ((falu_flags[6:1] & trap_mask) != 6'd0);
    end
`endif

endmodule

// File: tb/tb_fp_exec_sequencer.sv
// Self-checking bench for fp_exec_sequencer: directed plan items plus randomized ops
// against a transaction-level model (latency table, mock ALU, sticky accumulator).
module tb_fp_exec_sequencer;

    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_dest;
    logic [3:0]  falu_opcode;
    logic [31:0] falu_a;
    logic [31:0] falu_b;
    logic [31:0] falu_result;
    logic [6:0]  falu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic [6:0]  out_flags;
    logic [5:0]  sticky_flags;
    logic        sticky_clear;
    logic        busy;
`ifdef FP_EXEC_TRAP_EN
    logic [5:0]  trap_mask;
    logic        trap;
`endif

    logic [6:0]  alu_flags;
    logic [5:0]  exp_sticky;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Mock ALU: the one adder case from the plan, otherwise an arbitrary operand mix.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'b0000 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a + b) ^ (b << 3) ^ {28'h0, op};
    endfunction

    function automatic int latency(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return LAT_ADD;
            4'd2:       return LAT_MUL;
            4'd4, 4'd5: return LAT_DIV;
            default:    return 1;
        endcase
    endfunction

    assign falu_result = alu_fn(falu_opcode, falu_a, falu_b);
    assign falu_flags  = alu_flags;

    fp_exec_sequencer #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
        .falu_opcode(falu_opcode), .falu_a(falu_a), .falu_b(falu_b),
        .falu_result(falu_result), .falu_flags(falu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clear(sticky_clear),
`ifdef FP_EXEC_TRAP_EN
        .trap_mask(trap_mask), .trap(trap),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one op at the next edge, follow it to capture, hold, then accept it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, input logic [6:0] flags, input int hold,
                          input bit clr_cap, input bit keep_valid);
        int          lat;
        logic [31:0] exp_res;
        lat     = latency(op);
        exp_res = alu_fn(op, a, b);
        check("idle_in_ready", in_ready, 1);
        in_opcode = op; in_a = a; in_b = b; in_dest = dest; alu_flags = flags;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (clr_cap && k == lat) sticky_clear = 1'b1;
            @(posedge clk); #1;
            sticky_clear = 1'b0;
            if (k < lat) begin
                check("exec_out_valid", out_valid, 0);
                check("exec_in_ready", in_ready, 0);
                check("exec_busy", busy, 1);
                check("exec_falu_op", falu_opcode, op);
                check("exec_falu_a", falu_a, a);
                check("exec_falu_b", falu_b, b);
            end
        end
        exp_sticky = (clr_cap ? 6'd0 : exp_sticky) | flags[6:1];
        check("cap_out_valid", out_valid, 1);
        check("cap_in_ready", in_ready, 0);
        check("cap_busy", busy, 1);
        check("cap_result", out_result, exp_res);
        check("cap_dest", out_dest, dest);
        check("cap_flags", out_flags, flags);
        check("cap_sticky", sticky_flags, exp_sticky);
`ifdef FP_EXEC_TRAP_EN
        check("cap_trap", trap, ((flags[6:1] & trap_mask) != 6'd0));
`endif
        alu_flags = $urandom();
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_result", out_result, exp_res);
            check("hold_dest", out_dest, dest);
            check("hold_flags", out_flags, flags);
            check("hold_falu_a", falu_a, a);
`ifdef FP_EXEC_TRAP_EN
            check("hold_trap", trap, 0);
`endif
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("acc_out_valid", out_valid, 0);
        check("acc_in_ready", in_ready, 1);
        check("acc_busy", busy, 0);
        check("acc_sticky", sticky_flags, exp_sticky);
        check("acc_falu_b", falu_b, b);
    endtask

    task automatic idle_clear();
        sticky_clear = 1'b1;
        @(posedge clk); #1;
        sticky_clear = 1'b0;
        exp_sticky   = '0;
        check("idle_clear_sticky", sticky_flags, exp_sticky);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_dest = '0;
        out_ready = 1'b0; sticky_clear = 1'b0; alu_flags = '0; exp_sticky = '0;
`ifdef FP_EXEC_TRAP_EN
        trap_mask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_dest", out_dest, 0);
        check("rst_flags", out_flags, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_falu_op", falu_opcode, 0);
        check("rst_falu_a", falu_a, 0);
        check("rst_falu_b", falu_b, 0);
`ifdef FP_EXEC_TRAP_EN
        check("rst_trap", trap, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(4'b0000, 32'h3F80_0000, 32'h4000_0000, 5'd7, 7'b0000000, 3, 1'b0, 1'b0);
        run_op(4'b0100, 32'h4120_0000, 32'h0000_0000, 5'd3, 7'b0000010, 0, 1'b0, 1'b0);
        idle_clear();
        run_op(4'b0010, 32'h7F00_0000, 32'h7F00_0000, 5'd1, 7'b1000000, 1, 1'b0, 1'b0);
        run_op(4'b0001, 32'h3F80_0001, 32'h3300_0000, 5'd2, 7'b0010000, 0, 1'b0, 1'b0);
        check("sticky_ovf_inx", sticky_flags, 6'b101000);
        idle_clear();
        run_op(4'b0010, 32'h0080_0000, 32'h0080_0000, 5'd4, 7'b0100000, 0, 1'b1, 1'b0);
        check("sticky_clear_capture", sticky_flags, 6'b010000);
        run_op(4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 7'b0000001, 2, 1'b0, 1'b1);

        // Reset in the third execute cycle of a divide.
        in_opcode = 4'b0100; in_a = 32'h4000_0000; in_b = 32'h4040_0000; in_dest = 5'd9;
        alu_flags = 7'b0010000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        exp_sticky = '0;
        check("mrst_busy", busy, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_sticky", sticky_flags, exp_sticky);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_in_ready_rel", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("mrst_no_valid", out_valid, 0);
        end
        check("mrst_sticky_after", sticky_flags, 0);

`ifdef FP_EXEC_TRAP_EN
        trap_mask = 6'b000100;
        run_op(4'b0000, 32'h3F80_0000, 32'h3380_0000, 5'd5, 7'b0001000, 1, 1'b0, 1'b0);
        trap_mask = 6'b000000;
        run_op(4'b0000, 32'h3F80_0000, 32'h3380_0000, 5'd5, 7'b0001000, 1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) idle_clear();
                else begin
                    @(posedge clk); #1;
                end
            end
`ifdef FP_EXEC_TRAP_EN
            trap_mask = 6'($urandom());
`endif
            run_op(4'($urandom()), $urandom(), $urandom(), 5'($urandom()), 7'($urandom()),
                   $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
